// File: rtl/cp_copy_block_engine_if.sv
// Bus bundle for the COPYBLOCK engine. It carries the command handshake,
// the source read port, the destination write port and the status outputs.
interface cp_copy_block_engine_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int VPID_W = 4
);
    // Command from the CP
    logic              iCmdValid;
    logic              oCmdReady;
    logic [VPID_W-1:0] iVpId;
    logic [LEN_W-1:0]  iBlkLen;
    logic              iTag;
    logic [ADDR_W-1:0] iDstOff;
    logic [ADDR_W-1:0] iSrcOff;

    // Source memory read port (data one cycle after the strobe)
    logic [ADDR_W-1:0] oSrcAddr;
    logic              oSrcReadEnable;
    logic [DATA_W-1:0] iSrcData;

    // Destination write port
    logic [VPID_W-1:0] oDstVpId;
    logic [ADDR_W-1:0] oDstAddr;
    logic [DATA_W-1:0] oDstData;
    logic              oDstWriteEnable;
    logic              iDstReady;

    // Status
    logic              oBusy;
    logic              oDone;
    logic              oDoneTag;

    // Engine side
    modport slave (
        input  iCmdValid, iVpId, iBlkLen, iTag, iDstOff, iSrcOff,
        input  iSrcData, iDstReady,
        output oCmdReady, oSrcAddr, oSrcReadEnable,
        output oDstVpId, oDstAddr, oDstData, oDstWriteEnable,
        output oBusy, oDone, oDoneTag
    );

    // CP / memory side
    modport master (
        output iCmdValid, iVpId, iBlkLen, iTag, iDstOff, iSrcOff,
        output iSrcData, iDstReady,
        input  oCmdReady, oSrcAddr, oSrcReadEnable,
        input  oDstVpId, oDstAddr, oDstData, oDstWriteEnable,
        input  oBusy, oDone, oDoneTag
    );
endinterface

// File: rtl/cp_copy_block_engine.sv
// COPYBLOCK engine: copies iBlkLen words from a source memory to a
// destination VP, one word at a time (read, capture, write), then pulses
// oDone with the command tag. Addresses wrap modulo 2^ADDR_W.
module cp_copy_block_engine #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int VPID_W = 4
) (
    input  logic                   Clock,
    input  logic                   Reset,
    cp_copy_block_engine_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPTURE,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t            state_reg,    state_next;
    logic [LEN_W-1:0]  cnt_reg,      cnt_next;
    logic [ADDR_W-1:0] src_addr_reg, src_addr_next;
    logic [ADDR_W-1:0] dst_addr_reg, dst_addr_next;
    logic [DATA_W-1:0] data_reg,     data_next;
    logic [VPID_W-1:0] vp_id_reg,    vp_id_next;
    logic              tag_reg,      tag_next;

    // State and datapath registers; reset aborts any copy in progress at once
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            src_addr_reg <= '0;
            dst_addr_reg <= '0;
            data_reg     <= '0;
            vp_id_reg    <= '0;
            tag_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            src_addr_reg <= src_addr_next;
            dst_addr_reg <= dst_addr_next;
            data_reg     <= data_next;
            vp_id_reg    <= vp_id_next;
            tag_reg      <= tag_next;
        end
    end

    // Next-state and datapath updates; command fields are sampled only in IDLE
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        src_addr_next = src_addr_reg;
        dst_addr_next = dst_addr_reg;
        data_next     = data_reg;
        vp_id_next    = vp_id_reg;
        tag_next      = tag_reg;

        case (state_reg)
            ST_IDLE: begin
                if (bus.iCmdValid) begin
                    vp_id_next    = bus.iVpId;
                    tag_next      = bus.iTag;
                    src_addr_next = bus.iSrcOff;
                    dst_addr_next = bus.iDstOff;
                    cnt_next      = bus.iBlkLen;
                    state_next    = (bus.iBlkLen == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                data_next  = bus.iSrcData;
                state_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (bus.iDstReady) begin
                    src_addr_next = src_addr_reg + ADDR_W'(1);
                    dst_addr_next = dst_addr_reg + ADDR_W'(1);
                    cnt_next      = cnt_reg - LEN_W'(1);
                    state_next    = (cnt_reg == LEN_W'(1)) ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Strobes decode straight from the state, so read and write are exclusive
    assign bus.oCmdReady       = (state_reg == ST_IDLE);
    assign bus.oBusy           = (state_reg != ST_IDLE);
    assign bus.oSrcReadEnable  = (state_reg == ST_READ);
    assign bus.oDstWriteEnable = (state_reg == ST_WRITE);
    assign bus.oDone           = (state_reg == ST_DONE);
    assign bus.oDoneTag        = (state_reg == ST_DONE) && tag_reg;
    assign bus.oSrcAddr        = src_addr_reg;
    assign bus.oDstAddr        = dst_addr_reg;
    assign bus.oDstData        = data_reg;
    assign bus.oDstVpId        = vp_id_reg;

endmodule
